// File: rtl/capture_uart_packetizer.sv
// capture_uart_packetizer
//   Drains the capture block's 16-bit transfer FIFO and frames the words into
//   byte packets for a UART transmitter:
//     HEADER, {hi,lo} per word, COUNT, SUM (XOR of payload bytes and COUNT).
//
// Ports
//   clk              system clock (slow domain shared with the capture FIFOs)
//   rst              asynchronous active-low reset
//   dataReadyToRead  capture transfer FIFO not empty
//   dataValid        dataOut valid, one or more cycles after dataRead
//   dataOut[15:0]    capture word
//   dataRead         one-cycle read strobe to the transfer FIFO
//   readyToTransmit  high while idle
//   tx_busy          UART busy; rises the cycle after tx_start
//   tx_start         one-cycle byte launch strobe
//   tx_data[7:0]     byte to send, held until the next tx_start
//   pkt_done         pulses together with the checksum byte launch
module capture_uart_packetizer #(
  parameter int         MAX_WORDS = 128,
  parameter logic [7:0] HEADER    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dataReadyToRead,
  input  logic        dataValid,
  input  logic [15:0] dataOut,
  output logic        dataRead,
  output logic        readyToTransmit,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        pkt_done
);

  typedef enum logic [2:0] {
    IDLE, HDR, RD_REQ, RD_WAIT, SEND_HI, SEND_LO, SEND_CNT, SEND_SUM
  } state_e;

  localparam logic [7:0] MAX_W = 8'(MAX_WORDS);

  state_e      state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  csum_q, csum_d;
  logic [15:0] word_q, word_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d;
  logic        pkt_done_q, pkt_done_d;
  logic        guard_q;
  logic        rd;
  logic        can_tx;

  // tx_start is registered, so the UART's busy flag shows up two cycles after
  // the launch decision; guard covers the decision cycle in between.
  assign can_tx = !tx_busy && !guard_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    csum_d     = csum_q;
    word_d     = word_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    pkt_done_d = 1'b0;
    rd         = 1'b0;
    case (state_q)
      IDLE: begin
        if (dataReadyToRead) begin
          count_d = '0;
          csum_d  = '0;
          state_d = HDR;
        end
      end
      HDR: begin
        if (can_tx) begin
          tx_start_d = 1'b1;
          tx_data_d  = HEADER;
          state_d    = RD_REQ;
        end
      end
      RD_REQ: begin
        // An empty FIFO or a full packet both close the packet here.
        if (dataReadyToRead && (count_q < MAX_W)) begin
          rd      = 1'b1;
          state_d = RD_WAIT;
        end else begin
          state_d = SEND_CNT;
        end
      end
      RD_WAIT: begin
        if (dataValid) begin
          word_d  = dataOut;
          state_d = SEND_HI;
        end
      end
      SEND_HI: begin
        if (can_tx) begin
          tx_start_d = 1'b1;
          tx_data_d  = word_q[15:8];
          csum_d     = csum_q ^ word_q[15:8];
          state_d    = SEND_LO;
        end
      end
      SEND_LO: begin
        if (can_tx) begin
          tx_start_d = 1'b1;
          tx_data_d  = word_q[7:0];
          csum_d     = csum_q ^ word_q[7:0];
          count_d    = count_q + 8'd1;
          state_d    = RD_REQ;
        end
      end
      SEND_CNT: begin
        if (can_tx) begin
          tx_start_d = 1'b1;
          tx_data_d  = count_q;
          csum_d     = csum_q ^ count_q;
          state_d    = SEND_SUM;
        end
      end
      SEND_SUM: begin
        if (can_tx) begin
          tx_start_d = 1'b1;
          tx_data_d  = csum_q;
          pkt_done_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      csum_q     <= '0;
      word_q     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      pkt_done_q <= 1'b0;
      guard_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      csum_q     <= csum_d;
      word_q     <= word_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      pkt_done_q <= pkt_done_d;
      guard_q    <= tx_start_d;
    end
  end

  // dataRead decodes from RD_REQ directly so it can only ever appear there;
  // RD_REQ always exits after one cycle, so it never repeats back-to-back.
  assign dataRead        = rd;
  assign readyToTransmit = (state_q == IDLE);
  assign tx_start        = tx_start_q;
  assign tx_data         = tx_data_q;
  assign pkt_done        = pkt_done_q;

endmodule

// File: tb/tb_capture_uart_packetizer.sv
// Bench for capture_uart_packetizer (MAX_WORDS=4): FIFO and UART models run on
// the falling edge, stimulus is applied 1 time unit after the rising edge.
module tb_capture_uart_packetizer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dataReadyToRead = 1'b0;
  logic        dataValid = 1'b0;
  logic [15:0] dataOut = '0;
  logic        dataRead;
  logic        readyToTransmit;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        pkt_done;

  always #5 clk = ~clk;

  capture_uart_packetizer #(.MAX_WORDS(4), .HEADER(8'hA5)) dut (
    .clk(clk), .rst(rst),
    .dataReadyToRead(dataReadyToRead), .dataValid(dataValid), .dataOut(dataOut),
    .dataRead(dataRead), .readyToTransmit(readyToTransmit),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data), .pkt_done(pkt_done)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FIFO model: the pop lands one cycle after the read strobe, like a real
  // FIFO whose empty flag updates after the read edge.
  logic [15:0] fifo[$];
  int          v_dly = 1;
  int          v_cnt = 0;
  logic [15:0] v_word = '0;
  bit          pop_pend = 0;

  always @(negedge clk) begin
    if (pop_pend) begin
      void'(fifo.pop_front());
      pop_pend = 0;
    end
    dataValid = 1'b0;
    if (v_cnt > 0) begin
      v_cnt--;
      if (v_cnt == 0) begin
        dataValid = 1'b1;
        dataOut   = v_word;
      end
    end
    if (dataRead) begin
      v_word   = fifo[0];
      pop_pend = 1;
      v_cnt    = v_dly;
    end
    dataReadyToRead = (fifo.size() != 0);
  end

  // UART model: busy rises the cycle after tx_start, lasts busy_n cycles.
  int busy_n = 2;
  int b_cnt = 0;
  bit b_pend = 0;
  bit b_m = 0;
  bit force_busy = 0;
  assign tx_busy = b_m | force_busy;

  always @(negedge clk) begin
    if (b_pend) begin
      b_m    = 1;
      b_cnt  = busy_n;
      b_pend = 0;
    end else if (b_m) begin
      b_cnt--;
      if (b_cnt <= 0) b_m = 0;
    end
    if (tx_start) b_pend = 1;
  end

  // Monitor: byte log, launch spacing, packet and read counts.
  logic [7:0] rx[$];
  int pkt_cnt = 0;
  int rd_cnt = 0;
  bit prev_ts = 0;

  always @(negedge clk) begin
    if (tx_start) begin
      rx.push_back(tx_data);
      chk("tx_start_spacing", 32'(prev_ts), 32'd0);
    end
    prev_ts = tx_start;
    if (pkt_done) begin
      pkt_cnt++;
      chk("idle_with_pkt_done", 32'(readyToTransmit), 32'd1);
    end
    if (dataRead) rd_cnt++;
  end

  typedef struct {
    int                nw;   // word i is w[nw-1-i]
    logic [7:0][15:0]  w;
    int                dly;
    int                busy;
    int                nb;   // byte i is b[nb-1-i]
    logic [19:0][7:0]  b;
    int                pk;
  } vec_t;

  vec_t tv[4];

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int stall_bad;
    logic [7:0] a;

    tv[0].nw = 2; tv[0].w = 128'({16'h1234, 16'hABCD});
    tv[0].dly = 1; tv[0].busy = 10; tv[0].pk = 1;
    tv[0].nb = 7; tv[0].b = 160'({8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h02, 8'h42});

    tv[1].nw = 6;
    tv[1].w = 128'({16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006});
    tv[1].dly = 1; tv[1].busy = 2; tv[1].pk = 2;
    tv[1].nb = 18;
    tv[1].b = 160'({8'hA5, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04,
                    8'h04, 8'h00,
                    8'hA5, 8'h00, 8'h05, 8'h00, 8'h06, 8'h02, 8'h01});

    tv[2].nw = 1; tv[2].w = 128'({16'hFF00});
    tv[2].dly = 3; tv[2].busy = 3; tv[2].pk = 1;
    tv[2].nb = 5; tv[2].b = 160'({8'hA5, 8'hFF, 8'h00, 8'h01, 8'hFE});

    tv[3].nw = 3; tv[3].w = 128'({16'h00FF, 16'h8001, 16'h7E7E});
    tv[3].dly = 2; tv[3].busy = 1; tv[3].pk = 1;
    tv[3].nb = 9;
    tv[3].b = 160'({8'hA5, 8'h00, 8'hFF, 8'h80, 8'h01, 8'h7E, 8'h7E, 8'h03, 8'h7D});

    // Reset state
    tick(); tick();
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_pkt_done", 32'(pkt_done), 32'd0);
    chk("rst_dataRead", 32'(dataRead), 32'd0);
    chk("rst_ready", 32'(readyToTransmit), 32'd1);
    rst = 1'b1;
    tick(); tick();

    // Table-driven packets
    for (int t = 0; t < 4; t++) begin
      v_dly = tv[t].dly; busy_n = tv[t].busy;
      rx.delete(); pkt_cnt = 0; rd_cnt = 0;
      for (int i = 0; i < tv[t].nw; i++) fifo.push_back(tv[t].w[tv[t].nw-1-i]);
      n = 0;
      while (!(pkt_cnt == tv[t].pk && fifo.size() == 0 && readyToTransmit) && n < 4000) begin
        tick(); n++;
      end
      chk($sformatf("v%0d_completes", t), 32'(n < 4000), 32'd1);
      repeat (30) tick();
      chk($sformatf("v%0d_nbytes", t), 32'(rx.size()), 32'(tv[t].nb));
      for (int i = 0; i < tv[t].nb; i++) begin
        a = (i < rx.size()) ? rx[i] : 8'hxx;
        chk($sformatf("v%0d_byte%0d", t, i), 32'(a), 32'(tv[t].b[tv[t].nb-1-i]));
      end
      chk($sformatf("v%0d_pkts", t), 32'(pkt_cnt), 32'(tv[t].pk));
      chk($sformatf("v%0d_reads", t), 32'(rd_cnt), 32'(tv[t].nw));
      chk($sformatf("v%0d_ready", t), 32'(readyToTransmit), 32'd1);
    end

    // UART busy held high for 500 cycles while a word waits in SEND_HI
    rx.delete(); pkt_cnt = 0; rd_cnt = 0; busy_n = 2; v_dly = 1;
    fifo.push_back(16'h5AC3);
    n = 0;
    while (!dataRead && n < 200) begin tick(); n++; end
    chk("stall_read_seen", 32'(dataRead), 32'd1);
    force_busy = 1;
    stall_bad = 0;
    repeat (500) begin
      tick();
      if (tx_start !== 1'b0) stall_bad++;
      if (tx_data !== 8'hA5) stall_bad++;
    end
    chk("stall_outputs_quiet", 32'(stall_bad), 32'd0);
    chk("stall_nbytes", 32'(rx.size()), 32'd1);
    force_busy = 0;
    tick();
    chk("stall_release_start", 32'(tx_start), 32'd1);
    chk("stall_release_data", 32'(tx_data), 32'h5A);
    n = 0;
    while (pkt_cnt == 0 && n < 500) begin tick(); n++; end
    repeat (5) tick();
    chk("stall_nbytes_end", 32'(rx.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      logic [39:0] e;
      logic [7:0] eb;
      e  = {8'hA5, 8'h5A, 8'hC3, 8'h01, 8'h98};
      eb = e[39-8*i -: 8];
      a  = (i < rx.size()) ? rx[i] : 8'hxx;
      chk($sformatf("stall_byte%0d", i), 32'(a), 32'(eb));
    end

    // Reset asserted in SEND_LO, in the cycle tx_start is high
    rx.delete(); pkt_cnt = 0; rd_cnt = 0; busy_n = 3;
    fifo.push_back(16'hBEEF); fifo.push_back(16'h0102);
    n = 0;
    while (!(tx_start && tx_data == 8'hBE) && n < 500) begin tick(); n++; end
    chk("rst_mid_reached", 32'(n < 500), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_mid_tx_start", 32'(tx_start), 32'd0);
    chk("rst_mid_tx_data", 32'(tx_data), 32'd0);
    chk("rst_mid_pkt_done", 32'(pkt_done), 32'd0);
    chk("rst_mid_dataRead", 32'(dataRead), 32'd0);
    chk("rst_mid_ready", 32'(readyToTransmit), 32'd1);
    fifo.delete(); pop_pend = 0; v_cnt = 0;
    b_pend = 0; b_m = 0; b_cnt = 0;
    tick(); tick(); tick();
    rst = 1'b1;
    repeat (50) tick();
    chk("rst_mid_no_trailer", 32'(rx.size()), 32'd1);
    chk("rst_mid_no_pkt", 32'(pkt_cnt), 32'd0);
    chk("rst_mid_idle", 32'(readyToTransmit), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
